// File: rtl/led_pattern_ctrl.sv
// LED pattern controller: a prescaled tick steps OFF / BLINK / CHASE / BREATHE
// patterns, and the selected pattern drives a registered LED bus.
module led_pattern_ctrl #(
   parameter int unsigned CLK_DIV  = 12_000_000,
   parameter int unsigned N_LEDS   = 4,
   parameter int unsigned PWM_BITS = 8
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              en_i,
   input  logic [1:0]        mode_i,
   output logic [N_LEDS-1:0] leds_o,
   output logic              tick_o
);

   localparam int unsigned            DIV_W    = $clog2(CLK_DIV);
   localparam logic [DIV_W-1:0]       DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [PWM_BITS-1:0]    DUTY_MAX = '1;

   typedef enum logic [1:0] {
      MODE_OFF     = 2'd0,
      MODE_BLINK   = 2'd1,
      MODE_CHASE   = 2'd2,
      MODE_BREATHE = 2'd3
   } mode_e;

   logic [DIV_W-1:0]    div_q,   div_d;
   logic [PWM_BITS-1:0] pwm_q,   pwm_d;
   logic [PWM_BITS-1:0] duty_q,  duty_d;
   logic                dir_dn_q, dir_dn_d;
   mode_e               mode_q,  mode_d;
   logic [N_LEDS-1:0]   pos_q,   pos_d;
   logic                blink_q, blink_d;
   logic [N_LEDS-1:0]   leds_q,  leds_d;
   logic [N_LEDS-1:0]   pattern;
   logic                tick;

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values computed by the combinational block.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         div_q    <= '0;
         pwm_q    <= '0;
         duty_q   <= '0;
         dir_dn_q <= 1'b0;
         mode_q   <= MODE_OFF;
         pos_q    <= '0;
         blink_q  <= 1'b0;
         leds_q   <= '0;
      end else begin
         div_q    <= div_d;
         pwm_q    <= pwm_d;
         duty_q   <= duty_d;
         dir_dn_q <= dir_dn_d;
         mode_q   <= mode_d;
         pos_q    <= pos_d;
         blink_q  <= blink_d;
         leds_q   <= leds_d;
      end
   end

   always_comb begin
      pattern = '0;
      case (mode_q)
         MODE_OFF:     pattern = '0;
         MODE_BLINK:   pattern = {N_LEDS{blink_q}};
         MODE_CHASE:   pattern = pos_q;
         MODE_BREATHE: pattern = {N_LEDS{pwm_q < duty_q}};
         default:      pattern = '0;
      endcase
   end

   // NOTE: every signal written here gets a default first, so no path through
   // the branches below can leave one unassigned and infer a latch.
   always_comb begin
      div_d    = div_q;
      pwm_d    = pwm_q;
      duty_d   = duty_q;
      dir_dn_d = dir_dn_q;
      mode_d   = mode_q;
      pos_d    = pos_q;
      blink_d  = blink_q;
      leds_d   = '0;
      tick     = en_i && (div_q == DIV_LAST);

      if (en_i) begin
         div_d  = tick ? '0 : div_q + 1'b1;
         pwm_d  = pwm_q + 1'b1;
         leds_d = pattern;
         if (tick) begin
            if (mode_e'(mode_i) != mode_q) begin
               // A mode change only initialises; stepping resumes on the next tick.
               mode_d   = mode_e'(mode_i);
               blink_d  = 1'b1;
               pos_d    = '0;
               pos_d[0] = 1'b1;
               duty_d   = '0;
               dir_dn_d = 1'b0;
            end else begin
               case (mode_q)
                  MODE_BLINK: blink_d = ~blink_q;
                  MODE_CHASE: pos_d = (pos_q << 1) | (pos_q >> (N_LEDS - 1));
                  MODE_BREATHE: begin
                     if (!dir_dn_q) begin
                        if (duty_q == DUTY_MAX) begin
                           dir_dn_d = 1'b1;
                           duty_d   = DUTY_MAX - 1'b1;
                        end else begin
                           duty_d = duty_q + 1'b1;
                        end
                     end else begin
                        if (duty_q == '0) begin
                           dir_dn_d = 1'b0;
                           duty_d   = PWM_BITS'(1);
                        end else begin
                           duty_d = duty_q - 1'b1;
                        end
                     end
                  end
                  default: ;
               endcase
            end
         end
      end
   end

   assign leds_o = leds_q;
   assign tick_o = tick;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Self-checking bench for led_pattern_ctrl: a behavioural reference model
// queues the expected LED word each cycle; the bench pops it after the edge.
module tb_led_pattern_ctrl;

   localparam int CLK_DIV  = 4;
   localparam int N_LEDS   = 4;
   localparam int PWM_BITS = 3;
   localparam int DUTY_TOP = (1 << PWM_BITS) - 1;
   localparam int POS_TOP  = 1 << (N_LEDS - 1);
   localparam logic [N_LEDS-1:0] ALL_ON = '1;

   logic              clk_i   = 1'b0;
   logic              rst_n_i = 1'b1;
   logic              en_i    = 1'b0;
   logic [1:0]        mode_i  = 2'd0;
   logic [N_LEDS-1:0] leds_o;
   logic              tick_o;

   led_pattern_ctrl #(
      .CLK_DIV  (CLK_DIV),
      .N_LEDS   (N_LEDS),
      .PWM_BITS (PWM_BITS)
   ) dut (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .en_i    (en_i),
      .mode_i  (mode_i),
      .leds_o  (leds_o),
      .tick_o  (tick_o)
   );

   always #5 clk_i = ~clk_i;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int first_tick = -1;

   logic [N_LEDS-1:0] exp_q[$];

   // Reference model state, plain integers.
   int m_div, m_pwm, m_mode, m_pos, m_duty;
   bit m_blink, m_up;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_div = 0; m_pwm = 0; m_mode = 0; m_pos = 0; m_duty = 0;
      m_blink = 1'b0; m_up = 1'b1;
   endtask

   function automatic logic [N_LEDS-1:0] model_pattern();
      case (m_mode)
         1:       return m_blink ? ALL_ON : '0;
         2:       return N_LEDS'(m_pos);
         3:       return (m_pwm < m_duty) ? ALL_ON : '0;
         default: return '0;
      endcase
   endfunction

   // One clock: drive at the falling edge, check the tick strobe mid-cycle,
   // push the expected LED word, and compare it just after the rising edge.
   task automatic cycle(input logic en, input logic [1:0] mode);
      logic [N_LEDS-1:0] nxt;
      bit tk;
      @(negedge clk_i);
      en_i   = en;
      mode_i = mode;
      cyc++;
      #1;
      tk = en && (m_div == CLK_DIV - 1);
      check("tick_o", 32'(tick_o), 32'(tk));
      if (tick_o && first_tick < 0) first_tick = cyc;
      nxt = '0;
      if (en) begin
         nxt   = model_pattern();
         m_div = (m_div + 1) % CLK_DIV;
         m_pwm = (m_pwm + 1) % (1 << PWM_BITS);
         if (tk) begin
            if (int'(mode) != m_mode) begin
               m_mode = int'(mode); m_blink = 1'b1; m_pos = 1; m_duty = 0; m_up = 1'b1;
            end else if (m_mode == 1) begin
               m_blink = !m_blink;
            end else if (m_mode == 2) begin
               m_pos = (m_pos == POS_TOP) ? 1 : m_pos * 2;
            end else if (m_mode == 3) begin
               if (m_up) begin
                  if (m_duty == DUTY_TOP) begin m_up = 1'b0; m_duty = DUTY_TOP - 1; end
                  else m_duty = m_duty + 1;
               end else begin
                  if (m_duty == 0) begin m_up = 1'b1; m_duty = 1; end
                  else m_duty = m_duty - 1;
               end
            end
         end
      end
      exp_q.push_back(nxt);
      @(posedge clk_i);
      #1;
      check("leds_o", 32'(leds_o), 32'(exp_q.pop_front()));
   endtask

   initial begin
      model_reset();
      #3 rst_n_i = 1'b0;
      #1;
      check("rst_leds", 32'(leds_o), 32'd0);
      check("rst_tick", 32'(tick_o), 32'd0);
      @(posedge clk_i);
      #2 rst_n_i = 1'b1;

      // CHASE from reset: first tick in cycle 4, then rotate every 4 cycles.
      for (int i = 0; i < 20; i++) cycle(1'b1, 2'd2);
      check("first_tick_cycle", 32'(first_tick), 32'd4);

      // Park on pos=0100, pause for 10 cycles, then resume.
      for (int i = 0; i < 16 && m_pos != 4; i++) cycle(1'b1, 2'd2);
      cycle(1'b1, 2'd2);
      for (int i = 0; i < 10; i++) cycle(1'b0, 2'd2);
      for (int i = 0; i < 8; i++) cycle(1'b1, 2'd2);

      // Mode change 2 -> 1 in the middle of a prescaler interval.
      for (int i = 0; i < 16 && m_div != 1; i++) cycle(1'b1, 2'd2);
      for (int i = 0; i < 14; i++) cycle(1'b1, 2'd1);

      // Enable falls on a tick cycle together with a mode request: no load.
      for (int i = 0; i < 8 && m_div != CLK_DIV - 1; i++) cycle(1'b1, 2'd1);
      for (int i = 0; i < 3; i++) cycle(1'b0, 2'd2);
      for (int i = 0; i < 8; i++) cycle(1'b1, 2'd1);

      // BREATHE over a full up/down duty sweep.
      for (int i = 0; i < 72; i++) cycle(1'b1, 2'd3);

      // Asynchronous reset between edges in a tick cycle of BREATHE.
      for (int i = 0; i < 8 && m_div != CLK_DIV - 1; i++) cycle(1'b1, 2'd3);
      #2;
      check("pre_rst_tick", 32'(tick_o), 32'd1);
      rst_n_i = 1'b0;
      #1;
      check("mid_rst_leds", 32'(leds_o), 32'd0);
      check("mid_rst_tick", 32'(tick_o), 32'd0);
      model_reset();
      cyc = 0;
      first_tick = -1;
      @(posedge clk_i);
      #2 rst_n_i = 1'b1;
      for (int i = 0; i < 20; i++) cycle(1'b1, 2'd3);
      check("first_tick_after_rst", 32'(first_tick), 32'd4);

      // Back to OFF.
      for (int i = 0; i < 10; i++) cycle(1'b1, 2'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/led_pattern_ctrl.md
LED_PATTERN_CTRL -- requirements
Module: led_pattern_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 12_000_000: clock cycles per pattern tick, legal range >= 2.
REQ-002 SHALL have parameter N_LEDS, default 4: LED channel count, legal range >= 1.
REQ-003 SHALL have parameter PWM_BITS, default 8: PWM counter and duty width, legal range >= 2.
REQ-004 SHALL have port clk_i, input, 1: the single clock; one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port rst_n_i, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port en_i, input, 1: run enable.
REQ-007 SHALL have port mode_i, input, 2: requested mode (0 OFF, 1 BLINK, 2 CHASE, 3 BREATHE).
REQ-008 SHALL have port leds_o, output, N_LEDS: registered LED drive, bit 0 = LED 0.
REQ-009 SHALL have port tick_o, output, 1: one-cycle tick strobe.

Function
REQ-010 Prescaler div_cnt SHALL count 0..CLK_DIV-1 when en_i=1, then wrap to 0.
REQ-011 tick_o SHALL be 1 exactly in cycles where div_cnt==CLK_DIV-1 and en_i=1, else 0.
REQ-012 With en_i=0: div_cnt, pwm_cnt, mode_q and all pattern state SHALL hold, and leds_o SHALL be 0 from the next edge.
REQ-013 mode_q SHALL load mode_i only on tick edges; mode_i changes between ticks SHALL have no effect.
REQ-014 A tick edge where mode_i != mode_q SHALL initialise: blink_q=1, pos=one-hot bit 0, duty=0, dir=up; no pattern step on that edge.
REQ-015 Other tick edges SHALL advance only the pattern of the current mode_q.
REQ-016 OFF: pattern SHALL be all zeros.
REQ-017 BLINK: blink_q SHALL toggle each tick, and pattern SHALL be all bits = blink_q.
REQ-018 CHASE: pos SHALL rotate left one bit per tick, bit N_LEDS-1 wrapping to bit 0, and pattern SHALL be pos.
REQ-019 CHASE with N_LEDS=1: pos SHALL stay 1.
REQ-020 BREATHE: pwm_cnt (PWM_BITS wide) SHALL increment every enabled cycle with natural wrap, and pattern SHALL be all bits = (pwm_cnt < duty).
REQ-021 BREATHE duty SHALL step +1 per tick when dir=up and -1 when down.
REQ-022 BREATHE at duty=2^PWM_BITS-1 with dir=up, the tick SHALL set dir=down and duty=max-1.
REQ-023 BREATHE at duty=0 with dir=down, the tick SHALL set dir=up and duty=1.
REQ-024 duty SHALL never overflow or underflow.
REQ-025 leds_o SHALL equal the pattern of the previous cycle's state: one-cycle latency after any state change.
REQ-026 If a mode change and en_i falling coincide, en_i=0 SHALL take priority and no mode load SHALL occur.

Reset
REQ-027 rst_n_i low SHALL immediately and asynchronously clear to 0: div_cnt, pwm_cnt, duty, mode_q (OFF), pos, blink_q, dir (up), leds_o and tick_o.
REQ-028 Release SHALL be synchronous to clk_i.
REQ-029 Reset mid-pattern SHALL discard all progress, and the first tick after release SHALL reload mode_i per REQ-014.

Verification (CLK_DIV=4, N_LEDS=4, PWM_BITS=3)
REQ-030 Release reset, en_i=1, mode_i=2 -> tick_o high in 4th cycle; leds_o=0001 next cycle, then 0010, 0100, 1000, 0001 every 4 cycles.
REQ-031 mode_i=1 steady -> leds_o 1111 after first tick, then toggling 0000/1111 every 4 cycles.
REQ-032 mode_i=3 -> duty sequence per tick 0,1,..,7,6,..,0,1; at duty=3, leds_o high exactly 3 of every 8 cycles; at duty=7, 7 of 8.
REQ-033 In CHASE at pos=0100, drop en_i for 10 cycles -> leds_o=0000, tick_o=0; restore en_i -> resumes 0100, next tick 1000 after the remaining prescaler count.
REQ-034 Change mode_i 2->1 mid-interval -> no change until next tick; then leds_o=1111 one cycle after tick.
REQ-035 Assert rst_n_i low mid-BREATHE between edges -> leds_o and tick_o 0 immediately; after release, first tick loads mode_i with duty=0.
